// File: rtl/kernel_window_reader_if.sv
// Stream bundle for the kernel window reader: pixel columns in, KxK windows out.
// The producer/consumer side is the master; the reader itself is the slave.
interface kernel_window_reader_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_WIDTH = 3
);
  logic [KERNEL_WIDTH*DATA_WIDTH-1:0]              in_data;
  logic                                            in_valid;
  logic                                            in_ready;
  logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0] out_window;
  logic                                            out_valid;
  logic                                            out_ready;
  logic                                            out_border;
  logic                                            out_last;
  logic                                            frame_done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_window, out_valid, out_border, out_last, frame_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_window, out_valid, out_border, out_last, frame_done
  );
endinterface

// File: rtl/kernel_window_reader.sv
// Shifts line-buffer pixel columns into a KxK window and tags each emitted window
// with row-wrap border and end-of-frame flags from its own column/row counters.
//
// state    | meaning
// S_IDLE   | waiting for the first column of a frame
// S_ACTIVE | streaming columns, one window per accepted column
// S_DRAIN  | last column taken; input blocked until the last window leaves
module kernel_window_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMG_WIDTH    = 854,
  parameter int IMG_HEIGHT   = 480,
  parameter int KERNEL_WIDTH = 3
) (
  input logic                   clk,
  input logic                   rst,
  kernel_window_reader_if.slave bus
);
  localparam int K  = KERNEL_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_BORDER = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - K);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t                  state;
  logic [CW-1:0]           col_cnt;
  logic [RW-1:0]           row_cnt;
  logic [DW-1:0]           win      [K][K];
  logic [DW-1:0]           win_next [K][K];
  logic [K*K*DW-1:0]       win_flat;
  logic [K*K*DW-1:0]       out_window_q;
  logic                    out_valid_q;
  logic                    out_border_q;
  logic                    out_last_q;
  logic                    frame_done_q;
  logic                    in_ready_c;
  logic                    accept;
  logic                    xfer;
  logic                    col_end;
  logic                    row_end;

  assign in_ready_c = (state != S_DRAIN) && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign xfer       = out_valid_q && bus.out_ready;
  assign col_end    = (col_cnt == COL_LAST);
  assign row_end    = (row_cnt == ROW_LAST);

  // win is indexed [row][col]; col 0 is the oldest column
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[r][c] = win[r][c+1];
      end
      win_next[r][K-1] = bus.in_data[r*DW +: DW];
      for (int c = 0; c < K; c++) begin
        win_flat[(r*K+c)*DW +: DW] = win_next[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      col_cnt      <= '0;
      row_cnt      <= '0;
      out_window_q <= '0;
      out_valid_q  <= 1'b0;
      out_border_q <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        win          <= win_next;
        out_window_q <= win_flat;
        out_valid_q  <= 1'b1;
        out_border_q <= (col_cnt < COL_BORDER);
        out_last_q   <= col_end && row_end;
        if (col_end) begin
          col_cnt <= '0;
          row_cnt <= row_end ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
        if (col_end && row_end) begin
          state <= S_DRAIN;
        end else if (state == S_IDLE) begin
          state <= S_ACTIVE;
        end
      end else if (xfer) begin
        out_valid_q <= 1'b0;
        if (state == S_DRAIN) begin
          state        <= S_IDLE;
          frame_done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_window = out_window_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_border = out_border_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: doc/kernel_window_reader.md
Name: kernel_window_reader

Overview:
- Consumer end of the line-buffer stream.
- Each beat takes one KERNEL_WIDTH-tall pixel column, with one pixel from each line-buffer fifo tap.
- Shifts the column into a KERNEL_WIDTH x KERNEL_WIDTH register window and emits one window per accepted column.
- Tracks column/row position and flags border windows itself (row wrap), replacing address-based border detection in the line buffer. Sits between the line buffer and the gradient/HOG cell stage.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 854, columns per image row (equals line-buffer fifo depth)
IMG_HEIGHT, 480, image rows
KERNEL_WIDTH, 3, window side length K (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset
in_data  input  KERNEL_WIDTH*DATA_WIDTH  pixel column; lane r at [r*DATA_WIDTH +: DATA_WIDTH], r=0 is the top (oldest) row
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data
out_window  output  KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH  element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; c=0 is the oldest column
out_valid  output  1  out_window valid
out_ready  input  1  downstream accepts window
out_border  output  1  window straddles a row boundary; consumer must not compute on it
out_last  output  1  last window of frame
frame_done  output  1  one-cycle pulse after the last window of a frame is accepted downstream

Behaviour:
- One clock clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_border=0, out_last=0, frame_done=0, out_window=0, window registers=0, col_cnt=0, row_cnt=0, state=S_IDLE. in_ready=1 after reset.
- Handshakes:
  - accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, single output register, no skid).
  - Output transfer = out_valid && out_ready.
  - While out_valid && !out_ready: out_window, out_border and out_last are held stable.
- Window shift on accept:
  - window column c <= column c+1 for c=0..K-2; column K-1 <= in_data.
  - out_window is loaded with the post-shift window the same edge, so latency is 1 cycle from accept to out_valid.
- Simultaneous transfer and accept: new window loads and out_valid stays 1. A transfer with no accept sets out_valid to 0.
- Counters:
  - col_cnt is $clog2(IMG_WIDTH) bits and increments on accept.
  - At IMG_WIDTH-1, col_cnt wraps to 0 and row_cnt increments.
  - row_cnt is $clog2(IMG_HEIGHT) bits, range 0..IMG_HEIGHT-K. The line buffer only delivers once K-1 lines are stored, so each frame has IMG_HEIGHT-K+1 input rows.
- Border:
  - out_border is registered with the window, and is 1 iff col_cnt (pre-increment, of the accepted column) < K-1.
  - Stale columns from the previous row remain in the window. They are not cleared; the flag marks them.
- out_last is registered with the window, and is 1 iff the accepted column has col_cnt=IMG_WIDTH-1 and row_cnt=IMG_HEIGHT-K.
- FSM:
  - S_IDLE: waiting for a frame; go to S_ACTIVE on the first accept.
  - S_ACTIVE: streaming; go to S_DRAIN on the accept with the out_last condition, and both counters reset to 0.
  - S_DRAIN: in_ready is forced to 0. On the transfer of the out_last window, go to S_IDLE and pulse frame_done for exactly the next cycle. The next frame starts from col/row 0.
- Reset mid-frame: all state returns to reset values on the next edge. Any pending window is dropped and no frame_done is issued.
- Windows are not cleared between frames.

Test Plan (bench parameters IMG_WIDTH=8, IMG_HEIGHT=5, K=3; lane r of column c in row y = 64*y+16*r+c):
1. Reset held 2 cycles -> out_valid=0, frame_done=0, out_window=0, in_ready=1; after release, state S_IDLE.
2. Row 0, columns 0..2, out_ready=1 -> three windows one cycle after each accept, with out_border=1,1,0. Third window is (r,c)=16r+c: (0,0)=0, (2,2)=34.
3. Column 4 accepted, then out_ready=0 for 3 cycles while in_valid=1 -> out_valid stays 1, window stays stable (column 2 element = 4), in_ready=0. On resume, column 5 is accepted with no loss or duplication.
4. Row wrap (row 0 column 7, then row 1 column 0) -> col_cnt 7->0, row_cnt 0->1. Next two windows have out_border=1, and the row-1 column-0 window's (0,2) element is 64.
5. Full frame (3 rows x 8 = 24 accepts) with out_ready=1 -> 24 windows. Only the 24th has out_last=1. in_ready=0 in S_DRAIN, frame_done pulses once the cycle after the final transfer, then state is S_IDLE.
6. rst asserted at row 1 column 5 with out_valid=1 -> next cycle out_valid=0, counters 0, no frame_done. A new frame then yields first windows with out_border=1,1,0.
